qed_commit_tracker: RTL and testbench

//  Symbolic-initial-state (SIF) commit tracker inside the QED-wrapped DUT.
//  - Latches the free formal input sif_trigger as the commit point T_C.
//  - Counts retired original and duplicate instructions after T_C.
//  - Emits qed_check_valid when the two counts match.
//  - Feeds the QED consistency checker: sif_commit, sif_commit_pulsed, qed_check_valid.

---
 rtl/qed_commit_tracker.sv | 169 ++++++++++++++++
 tb/tb_qed_commit_tracker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_commit_tracker.sv
// qed_commit_tracker
// Symbolic-initial-state commit tracker for a QED-wrapped core. A free input
// (sif_trigger_i) picks the commit point T_C; after T_C the block counts
// retired original and duplicate instructions and reports when the two
// counts agree, so the QED consistency checker knows when to compare state.
//
// Optional feature macro: QED_DUP_ORDER_CHECK_EN
//   defined   -> sticky qed_order_err_o flags a duplicate retiring while the
//                counts are already equal (duplicate ahead of its original)
//   undefined -> qed_order_err_o is tied 0, no check logic
//
// Ports
//   clk_i                 core clock, rising edge
//   rst_i                 asynchronous active-high reset
//   commit_valid_i        one instruction retires this cycle
//   commit_is_dup_i       retiring instruction is a duplicate (1) / original (0)
//   commit_is_nop_i       retiring instruction is a bubble, never counted
//   sif_trigger_i         free input selecting T_C
//   sif_state_o           FSM state: 0=IDLE 1=TRACK 2=HALT
//   sif_commit_o          sticky: T_C has occurred
//   sif_commit_pulsed_o   one-cycle pulse marking T_C
//   qed_num_orig_o        originals retired since T_C
//   qed_num_dup_o         duplicates retired since T_C
//   qed_check_valid_o     counts equal and nonzero while tracking
//   qed_cnt_ovf_o         sticky: a counter saturated
//   qed_order_err_o       sticky duplicate-ahead-of-original flag
//
// Handshake: commit_valid_i is a single-cycle qualifier sampled on every
// rising edge; there is no backpressure, each high cycle is one retire.
module qed_commit_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             commit_valid_i,
  input  logic             commit_is_dup_i,
  input  logic             commit_is_nop_i,
  input  logic             sif_trigger_i,
  output logic [1:0]       sif_state_o,
  output logic             sif_commit_o,
  output logic             sif_commit_pulsed_o,
  output logic [CNT_W-1:0] qed_num_orig_o,
  output logic [CNT_W-1:0] qed_num_dup_o,
  output logic             qed_check_valid_o,
  output logic             qed_cnt_ovf_o,
  output logic             qed_order_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HALT  = 2'd2,
    S_BAD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             commit_q, commit_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] orig_q, orig_d;
  logic [CNT_W-1:0] dup_q, dup_d;
  logic             ovf_q, ovf_d;

  logic cnt_ev;
  logic inc_orig;
  logic inc_dup;

  assign cnt_ev   = commit_valid_i & ~commit_is_nop_i;
  assign inc_orig = cnt_ev & ~commit_is_dup_i;
  assign inc_dup  = cnt_ev &  commit_is_dup_i;

  always_comb begin
    state_d  = state_q;
    commit_d = commit_q;
    pulse_d  = 1'b0;
    orig_d   = orig_q;
    dup_d    = dup_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        // A retire in the trigger cycle precedes T_C, so counters start at 0.
        if (sif_trigger_i) begin
          state_d  = S_TRACK;
          commit_d = 1'b1;
          pulse_d  = 1'b1;
          orig_d   = '0;
          dup_d    = '0;
        end
      end
      S_TRACK: begin
        // Saturating counters: an increment at all-ones freezes everything.
        if (inc_orig) begin
          if (&orig_q) begin
            ovf_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            orig_d = orig_q + 1'b1;
          end
        end else if (inc_dup) begin
          if (&dup_q) begin
            ovf_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            dup_d = dup_q + 1'b1;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef QED_DUP_ORDER_CHECK_EN
  logic order_err_q, order_err_d;

  // Equal counts mean every duplicate so far has its original; one more
  // duplicate now would run ahead of the original stream.
  always_comb begin
    order_err_d = order_err_q;
    if ((state_q == S_TRACK) && inc_dup && (dup_q == orig_q)) begin
      order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      order_err_q <= 1'b0;
    end else begin
      order_err_q <= order_err_d;
    end
  end

  assign qed_order_err_o = order_err_q;
`else
  assign qed_order_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      commit_q <= 1'b0;
      pulse_q  <= 1'b0;
      orig_q   <= '0;
      dup_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      commit_q <= commit_d;
      pulse_q  <= pulse_d;
      orig_q   <= orig_d;
      dup_q    <= dup_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sif_state_o         = state_q;
  assign sif_commit_o        = commit_q;
  assign sif_commit_pulsed_o = pulse_q;
  assign qed_num_orig_o      = orig_q;
  assign qed_num_dup_o       = dup_q;
  assign qed_cnt_ovf_o       = ovf_q;
  // Straight from registers: a count updated at an edge is visible that cycle.
  assign qed_check_valid_o   = (state_q == S_TRACK) && (orig_q == dup_q) &&
                               (orig_q != '0);

endmodule

// File: tb/tb_qed_commit_tracker.sv
// Directed bench for qed_commit_tracker with CNT_W=4 so saturation is reachable.
module tb_qed_commit_tracker;

  localparam int CNT_W = 4;
`ifdef QED_DUP_ORDER_CHECK_EN
  localparam logic ORDER_EN = 1'b1;
`else
  localparam logic ORDER_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             commit_valid;
  logic             commit_is_dup;
  logic             commit_is_nop;
  logic             sif_trigger;
  logic [1:0]       sif_state;
  logic             sif_commit;
  logic             sif_commit_pulsed;
  logic [CNT_W-1:0] qed_num_orig;
  logic [CNT_W-1:0] qed_num_dup;
  logic             qed_check_valid;
  logic             qed_cnt_ovf;
  logic             qed_order_err;

  int checks;
  int failures;

  qed_commit_tracker #(.CNT_W(CNT_W)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .commit_valid_i      (commit_valid),
    .commit_is_dup_i     (commit_is_dup),
    .commit_is_nop_i     (commit_is_nop),
    .sif_trigger_i       (sif_trigger),
    .sif_state_o         (sif_state),
    .sif_commit_o        (sif_commit),
    .sif_commit_pulsed_o (sif_commit_pulsed),
    .qed_num_orig_o      (qed_num_orig),
    .qed_num_dup_o       (qed_num_dup),
    .qed_check_valid_o   (qed_check_valid),
    .qed_cnt_ovf_o       (qed_cnt_ovf),
    .qed_order_err_o     (qed_order_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic d, input logic n, input logic t);
    commit_valid  = v;
    commit_is_dup = d;
    commit_is_nop = n;
    sif_trigger   = t;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic arm();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // tests
  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    checks++;
    if ({sif_state, sif_commit, sif_commit_pulsed, qed_num_orig, qed_num_dup,
         qed_check_valid, qed_cnt_ovf, qed_order_err} !== '0) begin
      failures++;
      $display("FAIL reset_during: state=%0d commit=%b pulse=%b orig=%0d dup=%0d valid=%b ovf=%b err=%b, required all 0",
               sif_state, sif_commit, sif_commit_pulsed, qed_num_orig, qed_num_dup,
               qed_check_valid, qed_cnt_ovf, qed_order_err);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({sif_state, sif_commit, sif_commit_pulsed, qed_num_orig, qed_num_dup,
         qed_check_valid, qed_cnt_ovf, qed_order_err} !== '0) begin
      failures++;
      $display("FAIL reset_after: state=%0d commit=%b pulse=%b orig=%0d dup=%0d valid=%b ovf=%b err=%b, required all 0",
               sif_state, sif_commit, sif_commit_pulsed, qed_num_orig, qed_num_dup,
               qed_check_valid, qed_cnt_ovf, qed_order_err);
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(i[0], i[1], i[2] & i[0], 1'b0);
      step();
      checks++;
      if ({sif_state, sif_commit, qed_num_orig, qed_num_dup, qed_check_valid} !== '0) begin
        failures++;
        $display("FAIL idle_hold[%0d]: state=%0d commit=%b orig=%0d dup=%0d valid=%b, required 0/0/0/0/0",
                 i, sif_state, sif_commit, qed_num_orig, qed_num_dup, qed_check_valid);
      end
    end
  endtask

  task automatic test_trigger();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    // cycle 5: trigger together with an original retire
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (sif_commit_pulsed !== 1'b1 || sif_commit !== 1'b1 || qed_num_orig !== 4'd0 ||
        sif_state !== 2'd1) begin
      failures++;
      $display("FAIL trigger_c6: pulse=%b commit=%b orig=%0d state=%0d, required 1/1/0/1",
               sif_commit_pulsed, sif_commit, qed_num_orig, sif_state);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (sif_commit_pulsed !== 1'b0 || sif_commit !== 1'b1) begin
      failures++;
      $display("FAIL trigger_c7: pulse=%b commit=%b, required 0/1",
               sif_commit_pulsed, sif_commit);
    end
  endtask

  task automatic test_counts();
    // rows: valid, dup, nop, exp_orig, exp_dup, exp_valid
    logic [3:0] vdn_v [5] = '{4'b1000, 4'b1000, 4'b1010, 4'b1100, 4'b1100};
    logic [3:0] exp_o [5] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] exp_d [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    logic       exp_v [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    arm();
    for (int i = 0; i < 5; i++) begin
      logic [3:0] r;
      r = vdn_v[i];
      drive(r[3], r[2], r[1], 1'b0);
      step();
      checks++;
      if (qed_num_orig !== exp_o[i] || qed_num_dup !== exp_d[i] ||
          qed_check_valid !== exp_v[i] || qed_order_err !== 1'b0) begin
        failures++;
        $display("FAIL counts[%0d]: orig=%0d dup=%0d valid=%b err=%b, required %0d/%0d/%b/0",
                 i, qed_num_orig, qed_num_dup, qed_check_valid, qed_order_err,
                 exp_o[i], exp_d[i], exp_v[i]);
      end
    end
    // trigger is ignored once tracking
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sif_commit_pulsed !== 1'b0 || qed_num_orig !== 4'd2 || qed_num_dup !== 4'd2 ||
        qed_check_valid !== 1'b1 || sif_state !== 2'd1) begin
      failures++;
      $display("FAIL retrigger: pulse=%b orig=%0d dup=%0d valid=%b state=%0d, required 0/2/2/1/1",
               sif_commit_pulsed, qed_num_orig, qed_num_dup, qed_check_valid, sif_state);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    arm();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      if (i < 16) begin
        checks++;
        if (qed_num_orig !== 4'(i) || qed_cnt_ovf !== 1'b0 || sif_state !== 2'd1) begin
          failures++;
          $display("FAIL ovf_count[%0d]: orig=%0d ovf=%b state=%0d, required %0d/0/1",
                   i, qed_num_orig, qed_cnt_ovf, sif_state, i);
        end
      end
    end
    checks++;
    if (qed_num_orig !== 4'd15 || qed_cnt_ovf !== 1'b1 || sif_state !== 2'd2 ||
        qed_check_valid !== 1'b0 || sif_commit !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sat: orig=%0d ovf=%b state=%0d valid=%b commit=%b, required 15/1/2/0/1",
               qed_num_orig, qed_cnt_ovf, sif_state, qed_check_valid, sif_commit);
    end
    // HALT freezes counters
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (qed_num_orig !== 4'd15 || qed_num_dup !== 4'd0 || sif_state !== 2'd2 ||
        qed_cnt_ovf !== 1'b1 || sif_commit_pulsed !== 1'b0) begin
      failures++;
      $display("FAIL halt_frozen: orig=%0d dup=%0d state=%0d ovf=%b pulse=%b, required 15/0/2/1/0",
               qed_num_orig, qed_num_dup, sif_state, qed_cnt_ovf, sif_commit_pulsed);
    end
  endtask

  task automatic test_reset_mid_track();
    do_reset();
    arm();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i >= 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (qed_num_orig !== 4'd3 || qed_num_dup !== 4'd2 || qed_check_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_counts: orig=%0d dup=%0d valid=%b, required 3/2/0",
               qed_num_orig, qed_num_dup, qed_check_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sif_state, sif_commit, sif_commit_pulsed, qed_num_orig, qed_num_dup,
         qed_check_valid, qed_cnt_ovf, qed_order_err} !== '0) begin
      failures++;
      $display("FAIL mid_reset: state=%0d commit=%b orig=%0d dup=%0d valid=%b, required all 0",
               sif_state, sif_commit, qed_num_orig, qed_num_dup, qed_check_valid);
    end
    #1;
    rst = 1'b0;
    step();
    arm();
    checks++;
    if (sif_commit_pulsed !== 1'b1 || sif_commit !== 1'b1 || sif_state !== 2'd1 ||
        qed_num_orig !== 4'd0 || qed_num_dup !== 4'd0) begin
      failures++;
      $display("FAIL rearm: pulse=%b commit=%b state=%0d orig=%0d dup=%0d, required 1/1/1/0/0",
               sif_commit_pulsed, sif_commit, sif_state, qed_num_orig, qed_num_dup);
    end
  endtask

  task automatic test_order();
    do_reset();
    arm();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (qed_order_err !== ORDER_EN || qed_num_dup !== 4'd1 || sif_state !== 2'd1) begin
      failures++;
      $display("FAIL order_first_dup: err=%b dup=%0d state=%0d, required %b/1/1",
               qed_order_err, qed_num_dup, sif_state, ORDER_EN);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (qed_order_err !== ORDER_EN || qed_num_orig !== 4'd2 || qed_num_dup !== 4'd1) begin
      failures++;
      $display("FAIL order_sticky: err=%b orig=%0d dup=%0d, required %b/2/1",
               qed_order_err, qed_num_orig, qed_num_dup, ORDER_EN);
    end
  endtask

  // sequence and report
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_idle_hold();
    test_trigger();
    test_counts();
    test_overflow();
    test_reset_mid_track();
    test_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
